// File: rtl/ball_pkg.sv
// ----------------------------------------------------------------------------
// ball_pkg
// Shared types and constants for the ball motion engine.
//   state_t  : serve/play/miss state encoding (also driven out on State)
//   KEY_*    : USB HID keycodes recognised by the engine
//   motion_t : signed per-frame motion, two's complement
// ----------------------------------------------------------------------------
package ball_pkg;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_t;

  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SERVE = 8'h2C;

  // Motion only ever holds small speeds, so its width is independent of the
  // coordinate width; the top sign-extends it onto the MotionX/MotionY ports.
  localparam int MOTION_W = 10;
  typedef logic signed [MOTION_W-1:0] motion_t;

endpackage

// File: rtl/ball_axis.sv
// ----------------------------------------------------------------------------
// ball_axis
// One-axis next-motion and clamped next-position logic (purely combinational).
// Optional feature macro: BALL_SPEEDUP_EN (bounce raises |motion| by one, up
// to MAX_STEP, on instances built with SPEEDUP=1).
//
// Ports:
//   i_pos      current centre coordinate (unsigned)
//   i_motion   current motion on this axis
//   i_bounce   collision bounce: invert motion (highest priority)
//   i_neg_req  force motion to -STEP
//   i_pos_req  force motion to +STEP (below i_neg_req)
//   o_at_lo    centre is at or beyond the low edge (pos <= MIN+BALL_SIZE)
//   o_at_hi    centre is at or beyond the high edge (pos+BALL_SIZE >= MAX)
//   o_motion   new motion for this frame
//   o_pos      i_pos + o_motion, clamped to [MIN+BALL_SIZE, MAX-BALL_SIZE]
// ----------------------------------------------------------------------------
module ball_axis
  import ball_pkg::*;
#(
  parameter int COORD_W   = 10,
  parameter int P_MIN     = 0,
  parameter int P_MAX     = 639,
  parameter int BALL_SIZE = 4,
  parameter int STEP      = 1,
  parameter int MAX_STEP  = 4,
  parameter bit SPEEDUP   = 1'b0
) (
  input  logic [COORD_W-1:0] i_pos,
  input  motion_t            i_motion,
  input  logic               i_bounce,
  input  logic               i_neg_req,
  input  logic               i_pos_req,
  output logic               o_at_lo,
  output logic               o_at_hi,
  output motion_t            o_motion,
  output logic [COORD_W-1:0] o_pos
);

  localparam int LO = P_MIN + BALL_SIZE;
  localparam int HI = P_MAX - BALL_SIZE;

`ifdef BALL_SPEEDUP_EN
  localparam bit BUILD_SPEEDUP = 1'b1;
`else
  localparam bit BUILD_SPEEDUP = 1'b0;
`endif
  localparam bit SPEEDUP_ON = SPEEDUP && BUILD_SPEEDUP;

  // Invert direction; with speed-up the magnitude grows by one per bounce,
  // capped at MAX_STEP.
  function automatic motion_t f_bounce(input motion_t m);
    int mag;
    mag = (m < 0) ? -int'(m) : int'(m);
    if (SPEEDUP_ON) begin
      mag = (mag + 1 > MAX_STEP) ? MAX_STEP : mag + 1;
    end
    return (m < 0) ? motion_t'(mag) : motion_t'(-mag);
  endfunction

  int w_sum;

  always_comb begin
    if (i_bounce) begin
      o_motion = f_bounce(i_motion);
    end else if (i_neg_req) begin
      o_motion = motion_t'(-STEP);
    end else if (i_pos_req) begin
      o_motion = motion_t'(STEP);
    end else begin
      o_motion = i_motion;
    end

    // Signed 32-bit sum so a step past either edge cannot wrap before clamping.
    w_sum = int'(i_pos) + int'(o_motion);
    if (w_sum < LO) begin
      w_sum = LO;
    end else if (w_sum > HI) begin
      w_sum = HI;
    end
    o_pos = w_sum[COORD_W-1:0];
  end

  // Edge tests only add constants to the position, so nothing can underflow.
  assign o_at_lo = (int'(i_pos) <= LO);
  assign o_at_hi = (int'(i_pos) + BALL_SIZE >= P_MAX);

endmodule

// File: rtl/ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// ball_motion_ctrl
// Per-frame ball motion engine: wall/collision bounce, keyboard steering and a
// serve/play/miss state machine with saturating per-side scores. The motion
// decided in a frame is applied to the position in that same frame.
// Optional feature macro: BALL_SPEEDUP_EN (X bounces speed the ball up).
//
// Ports:
//   frame_clk        frame-rate clock, all state updates on rising edge
//   Reset            asynchronous active-high reset
//   bit_on/bit_on_v  horizontal/vertical playfield collision this frame
//   keycode          USB HID keycode (0 = none)
//   BallX/BallY      ball centre
//   BallS            ball half-extent (constant)
//   MotionX/MotionY  signed motion, two's complement
//   State            0=SERVE, 1=PLAY, 2=MISS
//   MissL/MissR      one-frame pulse when the ball is lost on that side
//   ScoreL/ScoreR    saturating scores
// ----------------------------------------------------------------------------
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 639,
  parameter int Y_MIN        = 0,
  parameter int Y_MAX        = 479,
  parameter int BALL_SIZE    = 4,
  parameter int STEP         = 1,
  parameter int MAX_STEP     = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int SCORE_W      = 4
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               bit_on,
  input  logic               bit_on_v,
  input  logic [7:0]         keycode,
  output logic [COORD_W-1:0] BallX,
  output logic [COORD_W-1:0] BallY,
  output logic [COORD_W-1:0] BallS,
  output logic [COORD_W-1:0] MotionX,
  output logic [COORD_W-1:0] MotionY,
  output logic [1:0]         State,
  output logic               MissL,
  output logic               MissR,
  output logic [SCORE_W-1:0] ScoreL,
  output logic [SCORE_W-1:0] ScoreR
);

  localparam int CNT_W = (SERVE_FRAMES > 2) ? $clog2(SERVE_FRAMES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [COORD_W-1:0] X_CTR    = COORD_W'((X_MIN + X_MAX + 1) / 2);
  localparam logic [COORD_W-1:0] Y_CTR    = COORD_W'((Y_MIN + Y_MAX + 1) / 2);
  localparam motion_t            M_NEG    = motion_t'(-STEP);
  localparam motion_t            M_POS    = motion_t'(STEP);

  function automatic logic [SCORE_W-1:0] f_sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + 1'b1;
  endfunction

  state_t               r_state, w_state_nxt;
  logic [COORD_W-1:0]   r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
  motion_t              r_mot_x, r_mot_y, w_mot_x_nxt, w_mot_y_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_miss_l, r_miss_r, w_miss_l_nxt, w_miss_r_nxt;
  logic [SCORE_W-1:0]   r_score_l, r_score_r, w_score_l_nxt, w_score_r_nxt;

  logic                 w_x_lo, w_x_hi, w_y_lo, w_y_hi;
  logic                 w_y_neg, w_y_pos;
  motion_t              w_ax_mot_x, w_ax_mot_y;
  logic [COORD_W-1:0]   w_ax_pos_x, w_ax_pos_y;

  // Y steering priority: bottom edge, top edge, W, S.
  assign w_y_neg = w_y_hi | (~w_y_lo & (keycode == KEY_W));
  assign w_y_pos = ~w_y_hi & (w_y_lo | (keycode == KEY_S));

  ball_axis #(
    .COORD_W  (COORD_W),
    .P_MIN    (X_MIN),
    .P_MAX    (X_MAX),
    .BALL_SIZE(BALL_SIZE),
    .STEP     (STEP),
    .MAX_STEP (MAX_STEP),
    .SPEEDUP  (1'b1)
  ) u_axis_x (
    .i_pos    (r_pos_x),
    .i_motion (r_mot_x),
    .i_bounce (bit_on),
    .i_neg_req(1'b0),
    .i_pos_req(1'b0),
    .o_at_lo  (w_x_lo),
    .o_at_hi  (w_x_hi),
    .o_motion (w_ax_mot_x),
    .o_pos    (w_ax_pos_x)
  );

  ball_axis #(
    .COORD_W  (COORD_W),
    .P_MIN    (Y_MIN),
    .P_MAX    (Y_MAX),
    .BALL_SIZE(BALL_SIZE),
    .STEP     (STEP),
    .MAX_STEP (MAX_STEP),
    .SPEEDUP  (1'b0)
  ) u_axis_y (
    .i_pos    (r_pos_y),
    .i_motion (r_mot_y),
    .i_bounce (bit_on_v),
    .i_neg_req(w_y_neg),
    .i_pos_req(w_y_pos),
    .o_at_lo  (w_y_lo),
    .o_at_hi  (w_y_hi),
    .o_motion (w_ax_mot_y),
    .o_pos    (w_ax_pos_y)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    w_mot_x_nxt   = r_mot_x;
    w_mot_y_nxt   = r_mot_y;
    w_cnt_nxt     = r_cnt;
    w_miss_l_nxt  = 1'b0;
    w_miss_r_nxt  = 1'b0;
    w_score_l_nxt = r_score_l;
    w_score_r_nxt = r_score_r;

    case (r_state)
      SERVE: begin
        w_pos_x_nxt = X_CTR;
        w_pos_y_nxt = Y_CTR;
        if ((r_cnt == CNT_LAST) || (keycode == KEY_SERVE)) begin
          w_state_nxt = PLAY;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      PLAY: begin
        w_mot_x_nxt = w_ax_mot_x;
        w_mot_y_nxt = w_ax_mot_y;
        w_pos_x_nxt = w_ax_pos_x;
        w_pos_y_nxt = w_ax_pos_y;
        // A collision bounce on the edge frame saves the ball.
        // Entering MISS already shows the centred ball, the reset motion
        // toward the conceding side and the updated score.
        if (!bit_on && w_x_lo) begin
          w_state_nxt   = MISS;
          w_miss_l_nxt  = 1'b1;
          w_score_r_nxt = f_sat_inc(r_score_r);
          w_pos_x_nxt   = X_CTR;
          w_pos_y_nxt   = Y_CTR;
          w_mot_x_nxt   = M_NEG;
          w_mot_y_nxt   = '0;
        end else if (!bit_on && w_x_hi) begin
          w_state_nxt   = MISS;
          w_miss_r_nxt  = 1'b1;
          w_score_l_nxt = f_sat_inc(r_score_l);
          w_pos_x_nxt   = X_CTR;
          w_pos_y_nxt   = Y_CTR;
          w_mot_x_nxt   = M_POS;
          w_mot_y_nxt   = '0;
        end
      end

      MISS: begin
        w_state_nxt = SERVE;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = SERVE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= SERVE;
      r_pos_x   <= X_CTR;
      r_pos_y   <= Y_CTR;
      r_mot_x   <= M_NEG;
      r_mot_y   <= '0;
      r_cnt     <= '0;
      r_miss_l  <= 1'b0;
      r_miss_r  <= 1'b0;
      r_score_l <= '0;
      r_score_r <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_mot_x   <= w_mot_x_nxt;
      r_mot_y   <= w_mot_y_nxt;
      r_cnt     <= w_cnt_nxt;
      r_miss_l  <= w_miss_l_nxt;
      r_miss_r  <= w_miss_r_nxt;
      r_score_l <= w_score_l_nxt;
      r_score_r <= w_score_r_nxt;
    end
  end

  assign BallX   = r_pos_x;
  assign BallY   = r_pos_y;
  assign BallS   = COORD_W'(BALL_SIZE);
  assign MotionX = COORD_W'(r_mot_x);
  assign MotionY = COORD_W'(r_mot_y);
  assign State   = r_state;
  assign MissL   = r_miss_l;
  assign MissR   = r_miss_r;
  assign ScoreL  = r_score_l;
  assign ScoreR  = r_score_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ball_motion_ctrl
// Directed bench for ball_motion_ctrl at default parameters (speed-up off).
// Expected positions are worked out by hand from the starting point of each
// scenario and the number of frames stepped.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ball_motion_ctrl;

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic       bit_on;
  logic       bit_on_v;
  logic [7:0] keycode;
  logic [9:0] BallX, BallY, BallS, MotionX, MotionY;
  logic [1:0] State;
  logic       MissL, MissR;
  logic [3:0] ScoreL, ScoreR;

  int n_chk = 0;
  int n_err = 0;

  always #5 frame_clk = ~frame_clk;

  ball_motion_ctrl dut (
    .frame_clk(frame_clk),
    .Reset    (Reset),
    .bit_on   (bit_on),
    .bit_on_v (bit_on_v),
    .keycode  (keycode),
    .BallX    (BallX),
    .BallY    (BallY),
    .BallS    (BallS),
    .MotionX  (MotionX),
    .MotionY  (MotionY),
    .State    (State),
    .MissL    (MissL),
    .MissR    (MissR),
    .ScoreL   (ScoreL),
    .ScoreR   (ScoreR)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one frame and settle away from the edge.
  task automatic step();
    @(posedge frame_clk);
    #2;
  endtask

  function automatic int sgn(input logic [9:0] v);
    return int'($signed(v));
  endfunction

  initial begin
    Reset    = 1'b1;
    bit_on   = 1'b0;
    bit_on_v = 1'b0;
    keycode  = 8'h00;
    repeat (2) @(posedge frame_clk);
    #2;
    Reset = 1'b0;

    // Reset state
    chk("rst_x",      int'(BallX), 320);
    chk("rst_y",      int'(BallY), 240);
    chk("rst_size",   int'(BallS), 4);
    chk("rst_mx",     sgn(MotionX), -1);
    chk("rst_my",     sgn(MotionY), 0);
    chk("rst_state",  int'(State), 0);
    chk("rst_missl",  int'(MissL), 0);
    chk("rst_missr",  int'(MissR), 0);
    chk("rst_scl",    int'(ScoreL), 0);
    chk("rst_scr",    int'(ScoreR), 0);

    // Auto-serve after 60 frames at centre
    repeat (59) step();
    chk("serve_hold_state", int'(State), 0);
    chk("serve_hold_x",     int'(BallX), 320);
    step();
    chk("serve_to_play",    int'(State), 1);
    chk("serve_exit_x",     int'(BallX), 320);
    step();
    chk("play_first_x",     int'(BallX), 319);
    chk("play_first_y",     int'(BallY), 240);

    // Keyboard steering
    keycode = 8'h16; step();
    chk("key_s_my", sgn(MotionY), 1);
    chk("key_s_y",  int'(BallY), 241);
    chk("key_s_x",  int'(BallX), 318);
    keycode = 8'h1A; step();
    chk("key_w_my", sgn(MotionY), -1);
    chk("key_w_y",  int'(BallY), 240);
    keycode = 8'h16; step();
    chk("key_s2_y", int'(BallY), 241);
    chk("key_s2_x", int'(BallX), 316);
    keycode = 8'h00;

    // Bottom wall bounce in the same frame
    repeat (234) step();
    chk("bot_pre_y",  int'(BallY), 475);
    chk("bot_pre_my", sgn(MotionY), 1);
    chk("bot_pre_x",  int'(BallX), 82);
    step();
    chk("bot_y",  int'(BallY), 474);
    chk("bot_my", sgn(MotionY), -1);
    chk("bot_x",  int'(BallX), 81);

    // Collision bounce on the left edge frame saves the ball
    repeat (77) step();
    chk("edge_x",     int'(BallX), 4);
    chk("edge_y",     int'(BallY), 397);
    chk("edge_state", int'(State), 1);
    bit_on = 1'b1; step();
    chk("save_mx",    sgn(MotionX), 1);
    chk("save_x",     int'(BallX), 5);
    chk("save_state", int'(State), 1);
    chk("save_missl", int'(MissL), 0);
    chk("save_y",     int'(BallY), 396);
    bit_on_v = 1'b1; step();
    chk("both_mx", sgn(MotionX), -1);
    chk("both_x",  int'(BallX), 4);
    chk("both_my", sgn(MotionY), 1);
    chk("both_y",  int'(BallY), 397);
    bit_on = 1'b0; bit_on_v = 1'b0;

    // Left miss
    step();
    chk("missl_state", int'(State), 2);
    chk("missl_pulse", int'(MissL), 1);
    chk("missl_r",     int'(MissR), 0);
    chk("missl_scr",   int'(ScoreR), 1);
    chk("missl_scl",   int'(ScoreL), 0);
    chk("missl_x",     int'(BallX), 320);
    chk("missl_y",     int'(BallY), 240);
    chk("missl_mx",    sgn(MotionX), -1);
    chk("missl_my",    sgn(MotionY), 0);
    step();
    chk("after_missl_state", int'(State), 0);
    chk("after_missl_pulse", int'(MissL), 0);
    chk("after_missl_scr",   int'(ScoreR), 1);

    // Fifteen more left misses, space to serve; ScoreR saturates at 15
    for (int i = 2; i <= 16; i++) begin
      keycode = 8'h2C; step(); keycode = 8'h00;
      chk("sat_serve", int'(State), 1);
      repeat (316) step();
      chk("sat_edge_x", int'(BallX), 4);
      step();
      chk("sat_missl",   int'(MissL), 1);
      chk("sat_score_r", int'(ScoreR), (i > 15) ? 15 : i);
      step();
    end

    // Right miss after a bounce sends the ball right
    keycode = 8'h2C; step(); keycode = 8'h00;
    step();
    chk("r_start_x", int'(BallX), 319);
    bit_on = 1'b1; step(); bit_on = 1'b0;
    chk("r_bounce_mx", sgn(MotionX), 1);
    chk("r_bounce_x",  int'(BallX), 320);
    repeat (315) step();
    chk("r_edge_x",     int'(BallX), 635);
    chk("r_edge_state", int'(State), 1);
    step();
    chk("missr_state", int'(State), 2);
    chk("missr_pulse", int'(MissR), 1);
    chk("missr_l",     int'(MissL), 0);
    chk("missr_scl",   int'(ScoreL), 1);
    chk("missr_scr",   int'(ScoreR), 15);
    chk("missr_mx",    sgn(MotionX), 1);
    chk("missr_x",     int'(BallX), 320);
    step();
    chk("after_missr_state", int'(State), 0);
    chk("after_missr_pulse", int'(MissR), 0);
    chk("after_missr_mx",    sgn(MotionX), 1);
    keycode = 8'h2C; step(); keycode = 8'h00;
    step();
    chk("serve_right_x", int'(BallX), 321);

    // Asynchronous reset between frame edges
    #2;
    Reset = 1'b1;
    #1;
    chk("arst_x",     int'(BallX), 320);
    chk("arst_mx",    sgn(MotionX), -1);
    chk("arst_state", int'(State), 0);
    chk("arst_scl",   int'(ScoreL), 0);
    chk("arst_scr",   int'(ScoreR), 0);
    #1;
    Reset = 1'b0;
    step();
    chk("arst_serve_state", int'(State), 0);
    chk("arst_serve_x",     int'(BallX), 320);
    keycode = 8'h2C; step(); keycode = 8'h00;
    chk("arst_play", int'(State), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
